mem_ctrl: RTL and testbench
===========================

Name: mem_ctrl

Overview:
- Single-port memory controller and arbiter between instruction fetch (IF) and the MEM stage.
- Serialises 32-bit fetches and 1/2/4-byte loads/stores onto the byte-wide external RAM port.
- Assembles read bytes little-endian and returns them with a one-cycle done pulse.
- Holds writes to the I/O window while the host UART buffer is full.

Parameters:
- ADDR_W, 32, width of all byte addresses (if_addr, mem_addr, ram_a).
- IO_HI, 2'b11, value of addr[17:16] that marks the I/O window.

Ports:
- clk_in  in  1  system clock, rising edge
- rst_in  in  1  reset, asynchronous, active-low
- rdy_in  in  1  global ready; when low, all state and outputs hold
- if_req  in  1  fetch request, level, held until if_done
- if_addr  in  ADDR_W  fetch byte address
- if_clear  in  1  cancel any pending/active fetch (branch redirect)
- if_done  out  1  one-cycle pulse: if_inst valid
- if_inst  out  32  fetched word, little-endian
- mem_req  in  1  data request, level, held until mem_done
- mem_we  in  1  1 = store, 0 = load
- mem_len  in  2  00 = 1 byte, 01 = 2 bytes, 10 = 4 bytes (11 treated as 4)
- mem_addr  in  ADDR_W  data byte address
- mem_wdata  in  32  store data, byte 0 = bits [7:0]
- mem_done  out  1  one-cycle pulse: access complete
- mem_rdata  out  32  load data, zero-extended to 32 bits
- ram_din  in  8  RAM read data, valid the cycle after ram_a is presented
- ram_dout  out  8  RAM write data
- ram_a  out  ADDR_W  RAM byte address
- ram_wr  out  1  1 = write this cycle
- io_buffer_full  in  1  I/O write buffer full

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0. Reset mid-transaction aborts it with no done pulse.
- States: IDLE, RD, WR.
- Arbitration (IDLE only):
  - mem_req wins over if_req.
  - A started transaction is never preempted.
  - A fetch is not accepted in the same cycle if_clear is high.
- Acceptance edge E0:
  - Latch address, byte count N (1/2/4), write data and owner (IF or MEM).
  - Go to RD or WR.
- RD (N bytes):
  - ram_a = base+k for k = 0..N-1 in the cycles after edges E0..E(N-1); ram_wr = 0 throughout.
  - Byte k is captured from ram_din in the cycle after address k, into bits [8k+7:8k].
  - done pulse and data are valid in the cycle after edge E(N+1).
  - Latency is N+2 cycles from acceptance; a 4-byte fetch takes 6 cycles.
  - Unused upper bits of mem_rdata are 0.
- WR (N bytes):
  - Byte k is on ram_dout with ram_a = base+k and ram_wr = 1 for one cycle each, on consecutive cycles.
  - mem_done pulses in the cycle after the last byte.
  - Latency is N+1 cycles.
- I/O stall: before issuing each write byte, if addr[17:16] == IO_HI and io_buffer_full = 1, hold with ram_wr = 0 and retry next cycle. No stall applies to reads or non-I/O addresses.
- if_clear:
  - During an IF read: abort immediately, return to IDLE next edge, no if_done. Discard partially captured bytes.
  - No effect on MEM transactions.
- Done pulses:
  - if_done and mem_done are mutually exclusive and exactly one cycle wide.
  - if_inst / mem_rdata hold their value until the next completion of the same owner.
- Back-to-back: the controller returns to IDLE on the done cycle and may accept a new request on the next edge. A requester sees done before deasserting req, so a held req is never double-serviced.
- Address arithmetic wraps modulo 2^ADDR_W.
- rdy_in = 0 freezes state, counters and ram_wr (forced 0); done pulses are delayed, not lost.

Test Plan:
- Fetch: if_req, if_addr = 0x100, RAM[0x100..0x103] = 13 05 A0 00 -> ram_a 0x100..0x103 on consecutive cycles, ram_wr = 0. One-cycle if_done 6 cycles after acceptance with if_inst = 0x00A00513.
- Collision: if_req and mem_req (load, len = 01, addr 0x2002, RAM = 34 12) in the same cycle -> MEM served first, mem_rdata = 0x00001234 after 4 cycles. IF then accepted on the following edge.
- Store word 0xDEADBEEF to 0x400 -> ram_wr = 1 for 4 cycles, ram_a 0x400..0x403, ram_dout EF BE AD DE. mem_done on the 5th cycle.
- I/O stall: store byte 0x41 to 0x30000 with io_buffer_full high for 3 cycles -> ram_wr stays 0 during those 3 cycles. Write occurs in the first cycle after it drops, mem_done one cycle later.
- Redirect: if_clear asserted in the 3rd cycle of a fetch -> no if_done. IDLE next cycle; a new fetch at 0x200 completes normally.
- Reset: rst_in low mid-store after 2 bytes -> all outputs 0 immediately, no mem_done. After release the controller is IDLE and accepts the next request.

Source files
------------

// File: rtl/mem_ctrl.sv
// Single-port byte-wide RAM controller arbitrating between instruction fetch and the MEM stage.
// Words are serialised little-endian; writes to the I/O window wait while the UART buffer is full.
module mem_ctrl #(
  parameter int         ADDR_W = 32,
  parameter logic [1:0] IO_HI  = 2'b11
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_clear,
  output logic              if_done,
  output logic [31:0]       if_inst,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [1:0]        mem_len,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_wdata,
  output logic              mem_done,
  output logic [31:0]       mem_rdata,
  input  logic [7:0]        ram_din,
  output logic [7:0]        ram_dout,
  output logic [ADDR_W-1:0] ram_a,
  output logic              ram_wr,
  input  logic              io_buffer_full
);

  typedef enum logic [1:0] {IDLE, RD, WR} state_t;

  state_t            state;
  logic              owner_if;
  logic [ADDR_W-1:0] base;
  logic [2:0]        n;
  logic [2:0]        k;
  logic [31:0]       wdata;
  logic [31:0]       rbuf;
  logic              wr_q;
  logic              if_done_q;
  logic              mem_done_q;

  logic [2:0]        len_n;
  logic [ADDR_W-1:0] wr_addr;
  logic              stall_wr;
  logic              stall_acc;
  logic [1:0]        cap_idx;
  logic [31:0]       rmerged;
  logic [7:0]        wbyte;

  always_comb begin
    len_n     = (mem_len == 2'b00) ? 3'd1 : (mem_len == 2'b01) ? 3'd2 : 3'd4;
    wr_addr   = base + ADDR_W'(k);
    stall_wr  = (wr_addr[17:16] == IO_HI) && io_buffer_full;
    stall_acc = (mem_addr[17:16] == IO_HI) && io_buffer_full;
    wbyte     = wdata[{k[1:0], 3'b000} +: 8];
    // Byte k-2 arrives on ram_din at the edge with counter k; merge it so
    // the final byte can be returned on the same edge it is captured.
    cap_idx   = 2'(k - 3'd2);
    rmerged   = rbuf;
    rmerged[{cap_idx, 3'b000} +: 8] = ram_din;
  end

  // A frozen (rdy_in low) cycle must not write RAM or signal completion.
  assign ram_wr   = wr_q & rdy_in;
  assign if_done  = if_done_q & rdy_in;
  assign mem_done = mem_done_q & rdy_in;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state      <= IDLE;
      owner_if   <= 1'b0;
      base       <= '0;
      n          <= '0;
      k          <= '0;
      wdata      <= '0;
      rbuf       <= '0;
      wr_q       <= 1'b0;
      if_done_q  <= 1'b0;
      mem_done_q <= 1'b0;
      if_inst    <= '0;
      mem_rdata  <= '0;
      ram_dout   <= '0;
      ram_a      <= '0;
    end else if (rdy_in) begin
      if_done_q  <= 1'b0;
      mem_done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          wr_q <= 1'b0;
          if (mem_req) begin
            owner_if <= 1'b0;
            base     <= mem_addr;
            n        <= len_n;
            wdata    <= mem_wdata;
            rbuf     <= '0;
            if (mem_we) begin
              state <= WR;
              if (stall_acc) begin
                k <= 3'd0;
              end else begin
                ram_a    <= mem_addr;
                ram_dout <= mem_wdata[7:0];
                wr_q     <= 1'b1;
                k        <= 3'd1;
              end
            end else begin
              state <= RD;
              ram_a <= mem_addr;
              k     <= 3'd1;
            end
          end else if (if_req && !if_clear) begin
            owner_if <= 1'b1;
            base     <= if_addr;
            n        <= 3'd4;
            rbuf     <= '0;
            state    <= RD;
            ram_a    <= if_addr;
            k        <= 3'd1;
          end
        end
        RD: begin
          if (owner_if && if_clear) begin
            state <= IDLE;
          end else begin
            if (k < n) ram_a <= base + ADDR_W'(k);
            if (k >= 3'd2) rbuf <= rmerged;
            if (k == n + 3'd1) begin
              state <= IDLE;
              if (owner_if) begin
                if_done_q <= 1'b1;
                if_inst   <= rmerged;
              end else begin
                mem_done_q <= 1'b1;
                mem_rdata  <= rmerged;
              end
            end
            k <= k + 3'd1;
          end
        end
        WR: begin
          if (k == n) begin
            wr_q       <= 1'b0;
            mem_done_q <= 1'b1;
            state      <= IDLE;
          end else if (stall_wr) begin
            wr_q <= 1'b0;
          end else begin
            ram_a    <= wr_addr;
            ram_dout <= wbyte;
            wr_q     <= 1'b1;
            k        <= k + 3'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: a table of MEM transactions plus hand-written
// sequences for collision, I/O stall, redirect, rdy freeze and mid-store reset.
module tb_mem_ctrl;

  logic        clk_in;
  logic        rst_in;
  logic        rdy_in;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_clear;
  logic        if_done;
  logic [31:0] if_inst;
  logic        mem_req;
  logic        mem_we;
  logic [1:0]  mem_len;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_done;
  logic [31:0] mem_rdata;
  logic [7:0]  ram_din;
  logic [7:0]  ram_dout;
  logic [31:0] ram_a;
  logic        ram_wr;
  logic        io_buffer_full;

  mem_ctrl #(.ADDR_W(32), .IO_HI(2'b11)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .if_req(if_req), .if_addr(if_addr), .if_clear(if_clear),
    .if_done(if_done), .if_inst(if_inst),
    .mem_req(mem_req), .mem_we(mem_we), .mem_len(mem_len),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_done(mem_done), .mem_rdata(mem_rdata),
    .ram_din(ram_din), .ram_dout(ram_dout), .ram_a(ram_a), .ram_wr(ram_wr),
    .io_buffer_full(io_buffer_full)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // RAM model: registered read (data valid the cycle after the address), write on ram_wr.
  logic [7:0] ram [0:262143];
  always @(posedge clk_in) begin
    ram_din <= ram[ram_a[17:0]];
    if (ram_wr) ram[ram_a[17:0]] <= ram_dout;
  end

  int vectors = 0;
  int fails   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic do_mem(input logic we, input logic [1:0] len, input logic [31:0] addr,
                        input logic [31:0] wd, output logic [31:0] data, output int lat);
    int n;
    int widx;
    logic [31:0] ea;
    logic [31:0] sh;
    n = (len == 2'b00) ? 1 : (len == 2'b01) ? 2 : 4;
    mem_req = 1'b1; mem_we = we; mem_len = len; mem_addr = addr; mem_wdata = wd;
    lat = 0; widx = 0; data = '0;
    while (lat < 40) begin
      tick();
      lat++;
      if (ram_wr) begin
        ea = addr + 32'(widx);
        sh = wd >> (8 * widx);
        chk("wr_addr", ram_a, ea);
        chk("wr_byte", {24'h0, ram_dout}, {24'h0, sh[7:0]});
        widx++;
      end else if (!we && lat <= n) begin
        ea = addr + 32'(lat - 1);
        chk("rd_addr", ram_a, ea);
      end
      if (mem_done) begin
        data = mem_rdata;
        break;
      end
    end
    mem_req = 1'b0;
    if (!mem_done) chk("mem_timeout", 32'(lat), 32'hFFFF_FFFF);
    chk("wr_count", 32'(widx), we ? 32'(n) : 32'd0);
  endtask

  task automatic do_if(input logic [31:0] addr, output logic [31:0] data, output int lat);
    if_req = 1'b1; if_addr = addr; lat = 0; data = '0;
    while (lat < 40) begin
      tick();
      lat++;
      if (lat <= 4) chk("if_addr", ram_a, addr + 32'(lat - 1));
      if (if_done) begin
        data = if_inst;
        break;
      end
    end
    if_req = 1'b0;
    if (!if_done) chk("if_timeout", 32'(lat), 32'hFFFF_FFFF);
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  len;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        full;
    logic [31:0] exp_data;
    int          exp_lat;
  } vec_t;

  vec_t tbl [13];

  initial begin
    logic [31:0] d;
    int          lat;
    int          md, id, cyc, nwr;
    logic [31:0] a5, inst;

    tbl[0]  = '{1'b1, 2'b10, 32'h0000_0400, 32'hDEAD_BEEF, 1'b0, 32'h0,          5};
    tbl[1]  = '{1'b0, 2'b10, 32'h0000_0400, 32'h0,         1'b0, 32'hDEAD_BEEF,  6};
    tbl[2]  = '{1'b0, 2'b01, 32'h0000_0402, 32'h0,         1'b0, 32'h0000_DEAD,  4};
    tbl[3]  = '{1'b0, 2'b00, 32'h0000_0401, 32'h0,         1'b0, 32'h0000_00BE,  3};
    tbl[4]  = '{1'b1, 2'b01, 32'h0000_0500, 32'hCAFE_5678, 1'b0, 32'h0,          3};
    tbl[5]  = '{1'b0, 2'b10, 32'h0000_0500, 32'h0,         1'b0, 32'h0000_5678,  6};
    tbl[6]  = '{1'b1, 2'b00, 32'h0000_0501, 32'h1234_56A5, 1'b0, 32'h0,          2};
    tbl[7]  = '{1'b0, 2'b10, 32'h0000_0500, 32'h0,         1'b0, 32'h0000_A578,  6};
    tbl[8]  = '{1'b0, 2'b11, 32'h0000_0400, 32'h0,         1'b0, 32'hDEAD_BEEF,  6};
    tbl[9]  = '{1'b1, 2'b00, 32'h0002_0000, 32'h0000_0077, 1'b1, 32'h0,          2};
    tbl[10] = '{1'b0, 2'b00, 32'h0002_0000, 32'h0,         1'b1, 32'h0000_0077,  3};
    tbl[11] = '{1'b1, 2'b10, 32'hFFFF_FFFF, 32'h1122_3344, 1'b0, 32'h0,          5};
    tbl[12] = '{1'b0, 2'b10, 32'hFFFF_FFFF, 32'h0,         1'b0, 32'h1122_3344,  6};

    for (int i = 0; i < 262144; i++) ram[i] = 8'h00;
    ram[18'h100] = 8'h13; ram[18'h101] = 8'h05; ram[18'h102] = 8'hA0; ram[18'h103] = 8'h00;
    ram[18'h200] = 8'h93; ram[18'h201] = 8'h00; ram[18'h202] = 8'h10; ram[18'h203] = 8'h00;
    ram[18'h2002] = 8'h34; ram[18'h2003] = 8'h12;

    rst_in = 1'b0; rdy_in = 1'b1; if_req = 1'b0; if_addr = '0; if_clear = 1'b0;
    mem_req = 1'b0; mem_we = 1'b0; mem_len = 2'b00; mem_addr = '0; mem_wdata = '0;
    io_buffer_full = 1'b0;
    tick(); tick();
    chk("rst_if_done",   {31'h0, if_done},  32'h0);
    chk("rst_if_inst",   if_inst,           32'h0);
    chk("rst_mem_done",  {31'h0, mem_done}, 32'h0);
    chk("rst_mem_rdata", mem_rdata,         32'h0);
    chk("rst_ram_a",     ram_a,             32'h0);
    chk("rst_ram_dout",  {24'h0, ram_dout}, 32'h0);
    chk("rst_ram_wr",    {31'h0, ram_wr},   32'h0);
    rst_in = 1'b1;
    tick();

    // Fetch at 0x100
    do_if(32'h100, d, lat);
    chk("fetch_inst", d, 32'h00A0_0513);
    chk("fetch_lat",  32'(lat), 32'd6);
    tick();
    chk("fetch_pulse_width", {31'h0, if_done}, 32'h0);

    for (int i = 0; i < 13; i++) begin
      io_buffer_full = tbl[i].full;
      do_mem(tbl[i].we, tbl[i].len, tbl[i].addr, tbl[i].wdata, d, lat);
      chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(tbl[i].exp_lat));
      if (!tbl[i].we) chk($sformatf("vec%0d_data", i), d, tbl[i].exp_data);
      io_buffer_full = 1'b0;
      tick();
      chk($sformatf("vec%0d_done_width", i), {31'h0, mem_done}, 32'h0);
    end

    // Collision: MEM load wins, IF accepted on the edge after mem_done.
    mem_req = 1'b1; mem_we = 1'b0; mem_len = 2'b01; mem_addr = 32'h2002;
    if_req = 1'b1; if_addr = 32'h100;
    cyc = 0; md = 0; id = 0; a5 = '0; inst = '0;
    while (cyc < 40 && id == 0) begin
      tick();
      cyc++;
      if (mem_done && if_done) chk("done_exclusive", 32'h1, 32'h0);
      if (mem_done) begin
        md = cyc;
        chk("coll_rdata", mem_rdata, 32'h0000_1234);
        mem_req = 1'b0;
      end
      if (if_done) begin
        id = cyc;
        inst = if_inst;
        if_req = 1'b0;
      end
      if (cyc == 5) a5 = ram_a;
    end
    if_req = 1'b0; mem_req = 1'b0;
    chk("coll_mem_cycle", 32'(md), 32'd4);
    chk("coll_if_addr",   a5,      32'h100);
    chk("coll_if_cycle",  32'(id), 32'd10);
    chk("coll_if_inst",   inst,    32'h00A0_0513);
    tick();

    // I/O stall: byte store to 0x30000 while the buffer is full for 3 cycles.
    io_buffer_full = 1'b1;
    mem_req = 1'b1; mem_we = 1'b1; mem_len = 2'b00; mem_addr = 32'h0003_0000; mem_wdata = 32'h41;
    nwr = 0;
    for (int c = 1; c <= 3; c++) begin
      tick();
      if (ram_wr) nwr++;
      if (mem_done) nwr++;
    end
    chk("io_stall_no_wr", 32'(nwr), 32'd0);
    io_buffer_full = 1'b0;
    tick();
    chk("io_wr",      {31'h0, ram_wr},   32'h1);
    chk("io_wr_addr", ram_a,             32'h0003_0000);
    chk("io_wr_byte", {24'h0, ram_dout}, 32'h41);
    tick();
    chk("io_done",    {31'h0, mem_done}, 32'h1);
    mem_req = 1'b0;
    tick();

    // Redirect: if_clear in the 3rd cycle of a fetch, then a fetch at 0x200.
    if_req = 1'b1; if_addr = 32'h100;
    id = 0; cyc = 0; a5 = '0; inst = '0;
    tick(); tick(); tick();
    cyc = 3;
    if (if_done) id = cyc;
    if_clear = 1'b1; if_addr = 32'h200;
    tick();
    cyc = 4;
    if (if_done) id = cyc;
    if_clear = 1'b0;
    chk("redir_no_done", 32'(id), 32'd0);
    while (cyc < 40 && id == 0) begin
      tick();
      cyc++;
      if (cyc == 5) a5 = ram_a;
      if (if_done) begin
        id = cyc;
        inst = if_inst;
      end
    end
    if_req = 1'b0;
    chk("redir_new_addr",  a5,      32'h200);
    chk("redir_new_cycle", 32'(id), 32'd10);
    chk("redir_new_inst",  inst,    32'h0010_0093);
    tick();

    // rdy_in freeze during a byte store: write and done are delayed, not lost.
    mem_req = 1'b1; mem_we = 1'b1; mem_len = 2'b00; mem_addr = 32'h700; mem_wdata = 32'h5A;
    tick();
    chk("rdy_wr_before", {31'h0, ram_wr}, 32'h1);
    rdy_in = 1'b0;
    #1;
    nwr = 0;
    if (ram_wr) nwr++;
    tick();
    if (ram_wr || mem_done) nwr++;
    tick();
    if (ram_wr || mem_done) nwr++;
    chk("rdy_frozen", 32'(nwr), 32'd0);
    rdy_in = 1'b1;
    #1;
    chk("rdy_wr_resume", {31'h0, ram_wr}, 32'h1);
    tick();
    chk("rdy_done", {31'h0, mem_done}, 32'h1);
    mem_req = 1'b0;
    tick();
    do_mem(1'b0, 2'b00, 32'h700, 32'h0, d, lat);
    chk("rdy_readback", d, 32'h5A);
    tick();

    // Reset in the middle of a word store, after two bytes have been written.
    mem_req = 1'b1; mem_we = 1'b1; mem_len = 2'b10; mem_addr = 32'h600; mem_wdata = 32'hA1B2_C3D4;
    tick(); tick(); tick();
    rst_in = 1'b0;
    #1;
    chk("mrst_ram_wr",    {31'h0, ram_wr},   32'h0);
    chk("mrst_ram_a",     ram_a,             32'h0);
    chk("mrst_ram_dout",  {24'h0, ram_dout}, 32'h0);
    chk("mrst_mem_rdata", mem_rdata,         32'h0);
    chk("mrst_if_inst",   if_inst,           32'h0);
    mem_req = 1'b0;
    nwr = 0;
    tick();
    if (mem_done) nwr++;
    tick();
    if (mem_done) nwr++;
    rst_in = 1'b1;
    tick();
    if (mem_done) nwr++;
    chk("mrst_no_done", 32'(nwr), 32'd0);
    do_mem(1'b0, 2'b01, 32'h600, 32'h0, d, lat);
    chk("mrst_lo_half", d, 32'h0000_C3D4);
    chk("mrst_lat",     32'(lat), 32'd4);
    tick();
    do_mem(1'b0, 2'b01, 32'h602, 32'h0, d, lat);
    chk("mrst_hi_half", d, 32'h0000_0000);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
